// File: rtl/region_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : region_dispatcher
//  Purpose  : Accepts one request-meta beat at a time and dispatches it to the
//             least-loaded operator region. Equal loads are resolved by
//             last-served OID affinity when OID_AFFINITY_EN is defined,
//             otherwise by the lowest index. Also keeps the per-region
//             outstanding counters and the last OID served by each region,
//             and exports them as region_stats_out.
//  Options  : `define OID_AFFINITY_EN to enable the OID-affinity tie-break.
//  Revision : 1.0  initial release
// ============================================================================
module region_dispatcher #(
  parameter int HTTP_META_WIDTH   = 98,
  parameter int OPERATOR_ID_WIDTH = 16,
  parameter int QDEPTH            = 16,
  parameter int N_REGIONS         = 4,
  localparam int LOAD_BITS        = $clog2(QDEPTH),
  localparam int RB               = $clog2(N_REGIONS),
  localparam int STAT_W           = OPERATOR_ID_WIDTH + LOAD_BITS
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           meta_in_tvalid,
  output logic                           meta_in_tready,
  input  logic [HTTP_META_WIDTH-1:0]     meta_in_tdata,
  output logic [N_REGIONS-1:0]           req_valid,
  input  logic [N_REGIONS-1:0]           req_ready,
  output logic [HTTP_META_WIDTH-1:0]     req_meta,
  input  logic [N_REGIONS-1:0]           done_in,
  output logic [N_REGIONS*STAT_W-1:0]    region_stats_out,
  output logic [RB-1:0]                  lb_ctrl,
  output logic                           busy,
  output logic                           err_underflow
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SELECT   = 2'd1;
  localparam logic [1:0] S_DISPATCH = 2'd2;

  localparam logic [LOAD_BITS-1:0] LOAD_LIMIT = LOAD_BITS'(QDEPTH - 1);

  logic [1:0]                   state;
  logic [HTTP_META_WIDTH-1:0]   meta_q;
  logic [RB-1:0]                sel;

  logic [LOAD_BITS-1:0]         load     [N_REGIONS];
  logic [OPERATOR_ID_WIDTH-1:0] last_oid [N_REGIONS];

  logic [N_REGIONS-1:0]         eligible;
  logic [N_REGIONS-1:0]         oid_match;
  logic [N_REGIONS-1:0]         underflow_hit;

  logic                         found;
  logic [RB-1:0]                best_idx;
  logic [LOAD_BITS-1:0]         best_load;
  logic                         best_match;

  logic                         dispatch_fire;

  assign dispatch_fire  = (state == S_DISPATCH) && req_ready[sel];
  assign meta_in_tready = (state == S_IDLE) && !areset;
  assign busy           = (state != S_IDLE);
  assign req_meta       = meta_q;

  // Per-region bookkeeping: eligibility, affinity match, counters, stats export
  for (genvar i = 0; i < N_REGIONS; i++) begin : g_region
    logic inc;
    logic dec;

    assign inc = dispatch_fire && (sel == RB'(i));
    assign dec = done_in[i];

    assign eligible[i] = (load[i] < LOAD_LIMIT);
`ifdef OID_AFFINITY_EN
    assign oid_match[i] = (last_oid[i] == meta_q[OPERATOR_ID_WIDTH-1:0]);
`else
    assign oid_match[i] = 1'b0;
`endif
    // A completion against an empty counter is an error, unless a dispatch
    // to the same region lands on the same edge and cancels it out.
    assign underflow_hit[i] = dec && !inc && (load[i] == '0);

    assign req_valid[i] = (state == S_DISPATCH) && (sel == RB'(i));
    assign region_stats_out[i*STAT_W +: STAT_W] = {last_oid[i], load[i]};

    // Outstanding counter and last-served OID for this region
    always_ff @(posedge aclk) begin
      if (areset) begin
        load[i]     <= '0;
        last_oid[i] <= '0;
      end else begin
        if (inc && !dec) begin
          load[i] <= load[i] + LOAD_BITS'(1);
        end else if (!inc && dec && (load[i] != '0)) begin
          load[i] <= load[i] - LOAD_BITS'(1);
        end
        if (inc) begin
          last_oid[i] <= meta_q[OPERATOR_ID_WIDTH-1:0];
        end
      end
    end
  end

  // Least-loaded eligible region; scanning upward keeps the lowest index on ties
  always_comb begin
    found      = 1'b0;
    best_idx   = '0;
    best_load  = '0;
    best_match = 1'b0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (eligible[i] &&
          (!found || (load[i] < best_load) ||
           ((load[i] == best_load) && oid_match[i] && !best_match))) begin
        found      = 1'b1;
        best_idx   = RB'(i);
        best_load  = load[i];
        best_match = oid_match[i];
      end
    end
  end

  // Request FSM: accept meta, pick a region, hold the dispatch until accepted
  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= S_IDLE;
      meta_q  <= '0;
      sel     <= '0;
      lb_ctrl <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (meta_in_tvalid) begin
            meta_q <= meta_in_tdata;
            state  <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (found) begin
            sel   <= best_idx;
            state <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (req_ready[sel]) begin
            lb_ctrl <= sel;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_underflow <= 1'b0;
    end else if (|underflow_hit) begin
      err_underflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_region_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_region_dispatcher
//  Purpose  : Self-checking bench for region_dispatcher. Directed scenarios
//             followed by random traffic; a behavioural model tracks loads,
//             last OIDs and the request in flight, and a negedge monitor
//             compares every DUT output against it each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_region_dispatcher;

  localparam int W  = 98;
  localparam int O  = 16;
  localparam int Q  = 16;
  localparam int N  = 4;
  localparam int L  = 4;
  localparam int RB = 2;
  localparam int SW = N * (O + L);

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          tvalid = 1'b0;
  logic          tready;
  logic [W-1:0]  tdata = '0;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready = '1;
  logic [W-1:0]  req_meta;
  logic [N-1:0]  done_in = '0;
  logic [SW-1:0] stats;
  logic [RB-1:0] lb_ctrl;
  logic          busy;
  logic          err;

  region_dispatcher dut (
    .aclk             (aclk),
    .areset           (areset),
    .meta_in_tvalid   (tvalid),
    .meta_in_tready   (tready),
    .meta_in_tdata    (tdata),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_meta         (req_meta),
    .done_in          (done_in),
    .region_stats_out (stats),
    .lb_ctrl          (lb_ctrl),
    .busy             (busy),
    .err_underflow    (err)
  );

  always #5 aclk = ~aclk;

  // ---------------- reference model ----------------
  int           m_load [N];
  logic [O-1:0] m_oid  [N];
  int           m_lb;
  bit           m_err;
  int           m_pend;      // 0 none, 1 awaiting region choice, 2 offered to region
  int           m_sel;
  logic [W-1:0] sbq [$];
  bit           model_valid = 1'b0;
  bit           meta_hs_last = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Region choice from the rules: minimum load among regions below QDEPTH-1,
  // then OID affinity (if enabled), then lowest index.
  function automatic int pick(input logic [O-1:0] oid);
    int minl = Q;
    for (int i = 0; i < N; i++)
      if (m_load[i] <= Q - 2 && m_load[i] < minl) minl = m_load[i];
    if (minl == Q) return -1;
`ifdef OID_AFFINITY_EN
    for (int i = 0; i < N; i++)
      if (m_load[i] == minl && m_oid[i] == oid) return i;
`endif
    for (int i = 0; i < N; i++)
      if (m_load[i] == minl) return i;
    return -1;
  endfunction

  function automatic int min_load();
    int m = Q;
    for (int i = 0; i < N; i++) if (m_load[i] < m) m = m_load[i];
    return m;
  endfunction

  logic [SW-1:0] exp_stats;
  bit            meta_hs, disp;
  int            new_pend, choice;

  // Monitor: compare outputs to the model, then advance the model by one edge
  always @(negedge aclk) begin
    if (model_valid) begin
      for (int i = 0; i < N; i++) exp_stats[i*(O+L) +: (O+L)] = {m_oid[i], 4'(m_load[i])};
      chk("tready",    tready, (!areset && m_pend == 0));
      chk("busy",      busy, (m_pend != 0));
      chk("req_valid", req_valid, (m_pend == 2) ? (4'b0001 << m_sel) : 4'b0000);
      if (m_pend == 2 && sbq.size() > 0) chk("req_meta", req_meta, sbq[0]);
      chk("stats",     stats, exp_stats);
      chk("lb_ctrl",   lb_ctrl, m_lb);
      chk("err",       err, m_err);
    end
    if (areset) begin
      for (int i = 0; i < N; i++) begin m_load[i] = 0; m_oid[i] = '0; end
      m_lb = 0; m_err = 0; m_pend = 0; m_sel = 0;
      sbq.delete();
      model_valid  = 1'b1;
      meta_hs_last = 1'b0;
    end else if (model_valid) begin
      meta_hs  = tvalid && (m_pend == 0);
      disp     = (m_pend == 2) && req_ready[m_sel];
      new_pend = m_pend;
      if (m_pend == 1) begin
        choice = pick(sbq[0][O-1:0]);
        if (choice >= 0) begin m_sel = choice; new_pend = 2; end
      end
      for (int i = 0; i < N; i++) begin
        if (disp && m_sel == i && !done_in[i]) m_load[i]++;
        else if (!(disp && m_sel == i) && done_in[i]) begin
          if (m_load[i] == 0) m_err = 1'b1;
          else m_load[i]--;
        end
      end
      if (disp) begin
        m_oid[m_sel] = sbq[0][O-1:0];
        m_lb = m_sel;
        void'(sbq.pop_front());
        new_pend = 0;
      end
      if (meta_hs) begin
        sbq.push_back(tdata);
        new_pend = 1;
      end
      m_pend = new_pend;
      meta_hs_last = meta_hs;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge aclk); #1;
  endtask

  function automatic logic [W-1:0] mk(input logic [O-1:0] oid);
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    r[O-1:0] = oid;
    return r[W-1:0];
  endfunction

  task automatic send(input logic [W-1:0] m);
    bit ok = 1'b0;
    tdata  = m;
    tvalid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (meta_hs_last) begin ok = 1'b1; break; end
    end
    tvalid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout: handshake not seen, required within 100 cycles");
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (m_pend == 0) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL idle_timeout: request still pending, required done within 300 cycles");
    end
  endtask

  task automatic do_reset(input int n);
    areset = 1'b1;
    repeat (n) step();
    areset = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset / idle
    do_reset(2);
    chk("tready_after_reset", tready, 1'b1);

    // Basic dispatch
    send(mk(16'h0005));
    wait_idle();
    chk("basic_stat0", stats[19:0], {16'h0005, 4'd1});
    chk("basic_lb", lb_ctrl, 2'd0);

    // Least-load and affinity: build loads {2,1,1,3}, last_oid[2]=0x0007
    do_reset(1);
    for (int k = 0; k < 12; k++) begin
      send(mk((k == 10) ? 16'h0007 : 16'(16'h0100 + k)));
      wait_idle();
    end
    done_in = 4'b0111; step();
    done_in = 4'b0110; step();
    done_in = 4'b0000;
    send(mk(16'h0007));
    wait_idle();
`ifdef OID_AFFINITY_EN
    chk("affinity_sel", lb_ctrl, 2'd2);
`else
    chk("affinity_sel", lb_ctrl, 2'd1);
`endif

    // Full stall
    do_reset(1);
    for (int k = 0; k < 60; k++) begin
      send(mk(16'(16'h0200 + k)));
      wait_idle();
    end
    send(mk(16'h0ABC));
    repeat (5) step();
    chk("stall_valid", req_valid, 4'b0000);
    chk("stall_busy", busy, 1'b1);
    done_in = 4'b1000; step(); done_in = 4'b0000;
    wait_idle();
    chk("stall_lb", lb_ctrl, 2'd3);
    chk("stall_load3", stats[63:60], 4'd15);

    // Backpressure plus concurrent completion
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      send(mk(16'(16'h0300 + k)));
      wait_idle();
    end
    req_ready = 4'b1110;
    send(mk(16'h0BAD));
    repeat (5) step();
    chk("bp_valid", req_valid, 4'b0001);
    chk("bp_tready", tready, 1'b0);
    req_ready = 4'b1111;
    done_in   = 4'b0001;
    step();
    done_in   = 4'b0000;
    wait_idle();
    chk("bp_load0", stats[3:0], 4'd1);

    // Underflow and mid-flight reset
    do_reset(1);
    done_in = 4'b0010; step(); done_in = 4'b0000;
    step();
    chk("uf_err", err, 1'b1);
    chk("uf_load1", stats[23:20], 4'd0);
    req_ready = 4'b0000;
    send(mk(16'h0042));
    repeat (3) step();
    chk("mid_valid_before", req_valid, 4'b0001);
    areset = 1'b1;
    step();
    areset = 1'b0;
    req_ready = 4'b1111;
    chk("mid_valid_after", req_valid, 4'b0000);
    chk("mid_err_after", err, 1'b0);
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        req_ready[i] = ($urandom_range(0, 4) != 0);
        done_in[i]   = (m_load[i] > 0) && ($urandom_range(0, 5) == 0);
      end
      if (tvalid && meta_hs_last) tvalid = 1'b0;
      if (!tvalid && m_pend == 0 && min_load() < 12 && $urandom_range(0, 2) == 0) begin
        tdata  = mk(16'($urandom_range(0, 7)));
        tvalid = 1'b1;
      end
    end
    step();
    if (tvalid && meta_hs_last) tvalid = 1'b0;
    done_in   = 4'b0000;
    req_ready = 4'b1111;
    if (tvalid) begin
      for (int k = 0; k < 20 && !meta_hs_last; k++) step();
      tvalid = 1'b0;
    end
    step();
    wait_idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
